// File: rtl/nios2_system_jtag_ocimem_sequencer.sv
// ---------------------------------------------------------------------------
// nios2_system_jtag_ocimem_sequencer
//
// Purpose:
//   Sysclk-domain sequencer that turns decoded JTAG debug strobes into
//   single-word accesses on the on-chip debug memory. The memory is
//   single-ported and shared with the CPU monitor port through a
//   round-robin arbiter. JTAG read data and command status are returned
//   to the tck-side capture logic through MonDReg / monitor_ready /
//   monitor_error.
//
// Ports:
//   clk, reset_n                  system clock, synchronous active-low reset
//   jdo                           JTAG payload (address jdo[17+:ADDR_W],
//                                 data jdo[34:3], read-request jdo[35])
//   take_action_ocimem_a          load address, optionally read
//   take_action_ocimem_b          write data at address, then increment
//   take_no_action_ocimem_a       read at address, then increment
//   cpu_req/we/addr/wdata         CPU access request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid, cpu_rdata CPU grant, read-valid and read data
//   mem_en/we/addr/wdata          registered memory command
//   mem_rdata                     memory read data (cycle after mem_en)
//   MonDReg                       last JTAG read result
//   monitor_ready                 last JTAG command complete
//   monitor_error                 sticky dropped-strobe flag
//   busy                          JTAG command in progress
// ---------------------------------------------------------------------------
module nios2_system_jtag_ocimem_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_RDCAP = 2'd3;

    localparam logic [1:0] CMD_RD_A = 2'd0;
    localparam logic [1:0] CMD_WR_B = 2'd1;
    localparam logic [1:0] CMD_RD_N = 2'd2;

    localparam logic WIN_CPU  = 1'b0;
    localparam logic WIN_JTAG = 1'b1;

    logic [1:0]        state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              last_winner_q, last_winner_d;

    logic              anyStrobe;
    logic              idleDrop;
    logic              grantCpu;
    logic              unusedJdo;

    assign anyStrobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    // Only the highest-priority strobe is taken; any other strobe in the
    // same cycle is lost and must be reported.
    assign idleDrop  = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                     | (take_action_ocimem_b & take_no_action_ocimem_a);
    assign unusedJdo = ^{jdo[37:36], jdo[2:0]};

    // Next-state logic: command acceptance, arbitration between the latched
    // JTAG command and the CPU port, and completion bookkeeping. The CPU is
    // only ever granted in IDLE/ARB; ISSUE and RDCAP belong to the JTAG access.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        data_d        = data_q;
        mon_dreg_d    = mon_dreg_q;
        ready_d       = ready_q;
        error_d       = error_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        cpu_gnt_d     = 1'b0;
        cpu_rvalid_d  = cpu_gnt_q & ~mem_we_q;
        last_winner_d = last_winner_q;
        grantCpu      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d  = jdo[17 +: ADDR_W];
                    error_d = 1'b0;
                    if (jdo[35]) begin
                        cmd_d   = CMD_RD_A;
                        ready_d = 1'b0;
                        state_d = ST_ARB;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    cmd_d   = CMD_WR_B;
                    data_d  = DATA_W'(jdo[34:3]);
                    ready_d = 1'b0;
                    state_d = ST_ARB;
                end else if (take_no_action_ocimem_a) begin
                    cmd_d   = CMD_RD_N;
                    ready_d = 1'b0;
                    state_d = ST_ARB;
                end
                // The JTAG command is only being latched this cycle, so
                // nothing competes with the CPU yet.
                grantCpu = cpu_req;
            end
            ST_ARB: begin
                if (cpu_req && last_winner_q == WIN_JTAG) begin
                    grantCpu = 1'b1;
                end else begin
                    mem_en_d      = 1'b1;
                    mem_we_d      = (cmd_q == CMD_WR_B);
                    mem_addr_d    = addr_q;
                    mem_wdata_d   = data_q;
                    last_winner_d = WIN_JTAG;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_q == CMD_WR_B) begin
                    ready_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RDCAP;
                end
            end
            ST_RDCAP: begin
                mon_dreg_d = 32'(mem_rdata);
                ready_d    = 1'b1;
                if (cmd_q == CMD_RD_N) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grantCpu) begin
            mem_en_d      = 1'b1;
            mem_we_d      = cpu_we;
            mem_addr_d    = cpu_addr;
            mem_wdata_d   = cpu_wdata;
            cpu_gnt_d     = 1'b1;
            last_winner_d = WIN_CPU;
        end

        // Setting the error has priority over the clear done by an accepted
        // address load in the same cycle.
        if ((state_q != ST_IDLE && anyStrobe) || (state_q == ST_IDLE && idleDrop)) begin
            error_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset; a reset drops any
    // in-flight JTAG command and CPU grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cmd_q         <= CMD_RD_A;
            addr_q        <= '0;
            data_q        <= '0;
            mon_dreg_q    <= '0;
            ready_q       <= 1'b1;
            error_q       <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_gnt_q     <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            last_winner_q <= WIN_CPU;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            mon_dreg_q    <= mon_dreg_d;
            ready_q       <= ready_d;
            error_q       <= error_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_gnt_q     <= cpu_gnt_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            last_winner_q <= last_winner_d;
        end
    end

    assign cpu_gnt       = cpu_gnt_q;
    assign cpu_rvalid    = cpu_rvalid_q;
    assign cpu_rdata     = mem_rdata;
    assign mem_en        = mem_en_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign MonDReg       = mon_dreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nios2_system_jtag_ocimem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nios2_system_jtag_ocimem_sequencer
//
// Drives JTAG commands and CPU traffic into the sequencer, emulates the
// debug memory, and compares every observable result against a
// transaction-level model: a word array, the current JTAG address, the
// last read result and the sticky error flag.
// ---------------------------------------------------------------------------
module tb_nios2_system_jtag_ocimem_sequencer;

    localparam int K_LOAD = 0;
    localparam int K_RDA  = 1;
    localparam int K_WRB  = 2;
    localparam int K_RDN  = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        busy;

    always #5 clk = ~clk;

    nios2_system_jtag_ocimem_sequencer #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .cpu_req                 (cpu_req),
        .cpu_we                  (cpu_we),
        .cpu_addr                (cpu_addr),
        .cpu_wdata               (cpu_wdata),
        .cpu_gnt                 (cpu_gnt),
        .cpu_rvalid              (cpu_rvalid),
        .cpu_rdata               (cpu_rdata),
        .mem_en                  (mem_en),
        .mem_we                  (mem_we),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_rdata               (mem_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .busy                    (busy)
    );

    // Single-port memory emulator: writes land at the edge, read data is
    // registered so it appears the cycle after mem_en. A preload port lets
    // the stimulus fill it without a second writer process.
    logic [31:0] memArr [256];
    logic        preloadEn;
    logic [7:0]  preloadAddr;
    logic [31:0] preloadData;

    always @(posedge clk) begin
        if (preloadEn) begin
            memArr[preloadAddr] <= preloadData;
        end else if (mem_en) begin
            if (mem_we) memArr[mem_addr] <= mem_wdata;
            else        mem_rdata <= memArr[mem_addr];
        end
    end

    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] refMem [256];
    logic [7:0]  refAddr;
    logic [31:0] refMonD;
    logic        refErr;
    int          cpuMode;
    logic        expRvalid;
    logic [7:0]  rvAddr;
    logic        jtagWindow;
    logic        jtagGrantSeen;
    logic [7:0]  gAddr;
    logic        gWe;
    logic [31:0] gData;
    int          cpuLost;

    // One comparison: counts it, and on a mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Choose the next CPU request according to the current traffic mode:
    // 0 idle, 1 always requesting, 2 random.
    task automatic newCpuReq();
        cpu_addr  = 8'($urandom);
        cpu_we    = 1'($urandom);
        cpu_wdata = $urandom;
        case (cpuMode)
            0:       cpu_req = 1'b0;
            1:       cpu_req = 1'b1;
            default: cpu_req = ($urandom_range(0, 2) == 0);
        endcase
    endtask

    // Advance one clock, then at the falling edge check the CPU side and
    // record any JTAG grant for the command currently in flight.
    task automatic tick();
        @(negedge clk);
        checkOutput("cpu_rvalid", 64'(cpu_rvalid), 64'(expRvalid));
        if (expRvalid) checkOutput("cpu_rdata", 64'(cpu_rdata), 64'(refMem[rvAddr]));
        expRvalid = 1'b0;
        if (mem_en && !cpu_gnt) begin
            checkOutput("jtag_grant_expected", 64'(jtagWindow && !jtagGrantSeen), 64'(1));
            jtagGrantSeen = 1'b1;
            gAddr = mem_addr;
            gWe   = mem_we;
            gData = mem_wdata;
        end
        if (cpu_gnt) begin
            checkOutput("cpu_gnt_mem_en", 64'(mem_en), 64'(1));
            checkOutput("cpu_mem_addr", 64'(mem_addr), 64'(cpu_addr));
            checkOutput("cpu_mem_we", 64'(mem_we), 64'(cpu_we));
            if (cpu_we) begin
                checkOutput("cpu_mem_wdata", 64'(mem_wdata), 64'(cpu_wdata));
                refMem[cpu_addr] = cpu_wdata;
            end else begin
                expRvalid = 1'b1;
                rvAddr    = cpu_addr;
            end
            if (jtagWindow && !jtagGrantSeen) cpuLost++;
            newCpuReq();
        end else if (!cpu_req) begin
            newCpuReq();
        end
    endtask

    task automatic doReset(input int cycles);
        cpuMode                 = 0;
        cpu_req                 = 1'b0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        expRvalid               = 1'b0;
        reset_n                 = 1'b0;
        repeat (cycles) tick();
        reset_n = 1'b1;
        refAddr = 8'h00;
        refMonD = 32'h0;
        refErr  = 1'b0;
    endtask

    // Issue one JTAG command and follow it to completion, comparing the
    // memory access, latency, read result, address progression and error
    // flag against the model. expLost < 0 leaves the arbitration count free.
    task automatic applyStimulus(input int kind, input logic [7:0] addr, input logic [31:0] data,
                                 input bit simulDrop, input bit busyInject, input bit raiseCpu,
                                 input int expLost);
        logic [37:0] j;
        logic [7:0]  useAddr;
        bit          isWrite;
        int          n;
        j = 38'({$urandom, $urandom});
        j[35] = (kind == K_RDA);
        if (kind == K_WRB) j[34:3] = data;
        if (kind == K_LOAD || kind == K_RDA) j[24:17] = addr;
        jdo = j;
        take_action_ocimem_a    = (kind == K_LOAD || kind == K_RDA);
        take_action_ocimem_b    = (kind == K_WRB) || (simulDrop && kind != K_WRB && kind != K_RDN);
        take_no_action_ocimem_a = (kind == K_RDN) || (simulDrop && kind == K_WRB);

        if (kind == K_LOAD || kind == K_RDA) begin
            refAddr = addr;
            refErr  = 1'b0;
        end
        if (simulDrop && kind != K_RDN) refErr = 1'b1;
        useAddr = refAddr;
        isWrite = (kind == K_WRB);
        jtagGrantSeen = 1'b0;
        cpuLost = 0;

        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;

        if (kind == K_LOAD) begin
            checkOutput("load_busy", 64'(busy), 64'(0));
            checkOutput("load_ready", 64'(monitor_ready), 64'(1));
            checkOutput("load_error", 64'(monitor_error), 64'(refErr));
            return;
        end

        checkOutput("cmd_busy", 64'(busy), 64'(1));
        checkOutput("cmd_ready_low", 64'(monitor_ready), 64'(0));
        if (busyInject) begin
            jdo = 38'({$urandom, $urandom});
            take_action_ocimem_a = 1'b1;
            refErr = 1'b1;
        end
        if (raiseCpu) begin
            cpuMode = 1;
            newCpuReq();
        end
        jtagWindow = 1'b1;
        n = 0;
        while (!monitor_ready && n < 20) begin
            tick();
            n++;
            take_action_ocimem_a = 1'b0;
        end
        jtagWindow = 1'b0;
        checkOutput("ready_timeout", 64'(monitor_ready), 64'(1));
        checkOutput("jtag_granted", 64'(jtagGrantSeen), 64'(1));
        checkOutput("jtag_addr", 64'(gAddr), 64'(useAddr));
        checkOutput("jtag_we", 64'(gWe), 64'(isWrite));
        if (isWrite) checkOutput("jtag_wdata", 64'(gData), 64'(data));
        checkOutput("latency", 64'(n), 64'((isWrite ? 2 : 3) + cpuLost));
        checkOutput("rr_fair", 64'(cpuLost <= 1), 64'(1));
        if (expLost >= 0) checkOutput("lost_arbs", 64'(cpuLost), 64'(expLost));

        if (isWrite) refMem[useAddr] = data;
        else         refMonD = refMem[useAddr];
        if (kind == K_WRB || kind == K_RDN) refAddr = refAddr + 8'd1;

        checkOutput("MonDReg", 64'(MonDReg), 64'(refMonD));
        checkOutput("busy_done", 64'(busy), 64'(0));
        checkOutput("monitor_error", 64'(monitor_error), 64'(refErr));
    endtask

    initial begin
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_req                 = 1'b0;
        cpu_we                  = 1'b0;
        cpu_addr                = '0;
        cpu_wdata               = '0;
        cpuMode                 = 0;
        expRvalid               = 1'b0;
        jtagWindow              = 1'b0;
        jtagGrantSeen           = 1'b0;
        cpuLost                 = 0;
        reset_n                 = 1'b0;

        // Fill memory and model while reset is held.
        for (int i = 0; i < 256; i++) begin
            preloadEn   = 1'b1;
            preloadAddr = 8'(i);
            preloadData = (i == 16) ? 32'hDEADBEEF : $urandom;
            refMem[i]   = preloadData;
            tick();
        end
        preloadEn = 1'b0;
        doReset(2);

        // Reset values.
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_ready", 64'(monitor_ready), 64'(1));
        checkOutput("rst_error", 64'(monitor_error), 64'(0));
        checkOutput("rst_MonDReg", 64'(MonDReg), 64'(0));
        checkOutput("rst_mem_en", 64'(mem_en), 64'(0));
        checkOutput("rst_mem_we", 64'(mem_we), 64'(0));
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'(0));
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        checkOutput("rst_cpu_gnt", 64'(cpu_gnt), 64'(0));

        // Address load with read of 0x10, then a write proves the address
        // did not move.
        applyStimulus(K_RDA, 8'h10, 32'h0, 0, 0, 0, 0);
        checkOutput("deadbeef", 64'(MonDReg), 64'(32'hDEADBEEF));
        applyStimulus(K_WRB, 8'h00, 32'hCAFE0001, 0, 0, 0, 0);

        // Write at 0xFF wraps the address; reads follow at 0x00 and 0x01.
        applyStimulus(K_LOAD, 8'hFF, 32'h0, 0, 0, 0, -1);
        applyStimulus(K_WRB, 8'h00, 32'h12345678, 0, 0, 0, 0);
        applyStimulus(K_RDN, 8'h00, 32'h0, 0, 0, 0, 0);
        applyStimulus(K_RDN, 8'h00, 32'h0, 0, 0, 0, 0);

        // Contention: JTAG won last, so a CPU request appearing during ARB
        // wins once; with the CPU then requesting continuously, JTAG wins.
        applyStimulus(K_RDN, 8'h00, 32'h0, 0, 0, 1, 1);
        applyStimulus(K_RDA, 8'h20, 32'h0, 0, 0, 0, 0);
        applyStimulus(K_WRB, 8'h00, 32'hA5A5F00F, 0, 0, 0, 0);
        doReset(1);
        cpuMode = 1;
        newCpuReq();
        repeat (3) tick();
        applyStimulus(K_RDA, 8'h10, 32'h0, 0, 0, 0, 0);
        cpuMode = 0;
        repeat (3) tick();

        // Strobe while busy is dropped; next address load clears the error.
        applyStimulus(K_RDN, 8'h00, 32'h0, 0, 1, 0, 0);
        applyStimulus(K_RDA, 8'h33, 32'h0, 0, 0, 0, 0);

        // Simultaneous ocimem_a and ocimem_b: load taken, write dropped.
        applyStimulus(K_LOAD, 8'h40, 32'h0, 1, 0, 0, -1);
        applyStimulus(K_RDN, 8'h00, 32'h0, 0, 0, 0, 0);
        applyStimulus(K_RDA, 8'h41, 32'h0, 0, 0, 0, 0);

        // Reset while a read sits in ISSUE: nothing is captured afterwards.
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        jtagWindow    = 1'b1;
        jtagGrantSeen = 1'b0;
        tick();
        checkOutput("issue_grant", 64'(jtagGrantSeen), 64'(1));
        jtagWindow = 1'b0;
        doReset(1);
        checkOutput("midrst_ready", 64'(monitor_ready), 64'(1));
        checkOutput("midrst_MonDReg", 64'(MonDReg), 64'(0));
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        tick();
        checkOutput("midrst_nocap", 64'(MonDReg), 64'(0));
        applyStimulus(K_RDN, 8'h00, 32'h0, 0, 0, 0, 0);

        // Randomized commands with mixed CPU traffic.
        for (int t = 0; t < 80; t++) begin
            cpuMode = $urandom_range(0, 2);
            applyStimulus($urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                          $urandom,
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 4) == 0),
                          0, -1);
            repeat ($urandom_range(0, 2)) tick();
        end
        cpuMode = 0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/nios2_system_jtag_ocimem_sequencer.md
Name: nios2_system_jtag_ocimem_sequencer

Overview:
- Sysclk-domain controller that turns decoded JTAG debug strobes (take_action_ocimem_a/b, take_no_action_ocimem_a plus jdo payload) into single-word accesses on the on-chip debug memory.
- Shares that single-port memory with the CPU-side monitor port through a round-robin arbiter.
- Returns read data and status (MonDReg, monitor_ready, monitor_error) to the JTAG debug module's tck-side capture logic.

Parameters:
- ADDR_W, 8, word-address width of the debug memory.
- DATA_W, 32, data width; jdo data field fixed at jdo[34:3], so DATA_W must be 32.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk.
- jdo  in  38  JTAG data-out payload; valid in the cycle its strobe is high.
- take_action_ocimem_a  in  1  1-cycle strobe: load address = jdo[17+:ADDR_W]; if jdo[35]=1, also issue a read.
- take_action_ocimem_b  in  1  1-cycle strobe: write jdo[34:3] to the current address, then increment the address.
- take_no_action_ocimem_a  in  1  1-cycle strobe: read the current address, then increment the address.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  CPU write enable, qualified by cpu_req.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  1-cycle grant; coincides with the registered mem_en for the CPU access.
- cpu_rvalid  out  1  CPU read data valid, one cycle after a read grant.
- cpu_rdata  out  DATA_W  equals mem_rdata.
- mem_en  out  1  memory access enable (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en.
- MonDReg  out  32  last JTAG read result.
- monitor_ready  out  1  last JTAG command complete.
- monitor_error  out  1  sticky error flag.
- busy  out  1  JTAG command in progress (state != IDLE).

Behaviour:
- Reset (synchronous, reset_n=0 at a clk edge):
  - state=IDLE; address=0.
  - MonDReg=0, monitor_ready=1, monitor_error=0.
  - mem_en=mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_gnt=cpu_rvalid=0; last_winner=CPU.
  - Reset mid-operation discards the in-flight command and any CPU grant in progress.
- FSM states: IDLE, ARB, ISSUE, RDCAP.
- IDLE:
  - Accepts a strobe; latches the command type and data; clears monitor_ready.
  - Goes to ARB if a memory op is needed, else stays in IDLE.
  - An address-only load (ocimem_a with jdo[35]=0) completes in IDLE; monitor_ready stays 1.
- Strobe priority: ocimem_a > ocimem_b > no_action_ocimem_a. Lower-priority simultaneous strobes are dropped and set monitor_error.
- A strobe while busy=1 is dropped and sets monitor_error. The in-flight command is unaffected.
- monitor_error clears only on an accepted take_action_ocimem_a (or reset). If ocimem_a is accepted in the same cycle another strobe is dropped, the error is still set (set wins).
- ARB: round-robin between the JTAG command and cpu_req.
  - Sole requester wins.
  - If both request, the one that is not last_winner wins; last_winner updates on every grant.
  - A JTAG win registers mem_en/mem_we/mem_addr/mem_wdata and moves to ISSUE.
  - A CPU win registers the CPU access plus cpu_gnt; the FSM stays in ARB.
- IDLE/ARB with no JTAG pending: the CPU is granted every cycle cpu_req=1 (back-to-back allowed, one access per cycle).
- ISSUE:
  - Write: monitor_ready=1, address+=1, go to IDLE.
  - Read: go to RDCAP.
- RDCAP: MonDReg<=mem_rdata, monitor_ready=1, go to IDLE.
  - address+=1 for no_action_ocimem_a only; ocimem_a read does not increment.
- Address arithmetic: increment wraps modulo 2^ADDR_W (2^ADDR_W-1 -> 0).
- Latency, counted from the edge that samples the strobe to monitor_ready=1, with no CPU contention:
  - write: 2 cycles;
  - read: 3 cycles;
  - each lost arbitration adds 1 cycle.
- CPU timing: cpu_rvalid=1 exactly one cycle after a cpu_gnt with cpu_we=0. cpu_gnt/cpu_rvalid are never asserted for JTAG accesses.
- mem_en is low in any cycle with no grant.

Test Plan:
- Reset, then ocimem_a with jdo[17+:8]=0x10 and jdo[35]=1; preloaded mem[0x10]=0xDEADBEEF -> mem_en with addr 0x10 one cycle later; MonDReg=0xDEADBEEF and monitor_ready=1 3 cycles after the strobe; address stays 0x10.
- Load addr 0xFF, then ocimem_b with data 0x12345678, then no_action_ocimem_a -> write to 0xFF, address wraps to 0x00, read issued at 0x00, final address 0x01.
- cpu_req held continuously, JTAG read strobe arrives -> after reset JTAG wins first; subsequent contention alternates; CPU is never denied two consecutive contended cycles.
- Second strobe while busy=1 -> dropped, monitor_error=1, first command completes normally; the next accepted ocimem_a clears monitor_error.
- ocimem_a and ocimem_b in the same cycle -> address load taken, write dropped, monitor_error=1.
- reset_n low for 1 cycle while in ISSUE of a read -> monitor_ready=1, MonDReg=0, busy=0, no RDCAP capture; the next command behaves normally.
